count_n_modal: RTL and testbench
================================

Name: count_n_modal

Overview:
- Parametrised N-bit counter with selectable count mode, succeeding the fixed 8-bit up-counter (clk/res/EN/load/CNT_In/CNT).
- Adds:
  - programmable modulus (MAX_VAL)
  - up/down direction
  - wrap, saturate and one-shot modes
  - integrated clock-enable prescaler
  - terminal-count pulse and one-shot done flag
- Used as the general timer/counter primitive in datapath and control blocks.

Parameters:
- WIDTH, 8, counter width in bits.
- MAX_VAL, 2**WIDTH-1, terminal value for up-count and wrap target for down-count. Must satisfy 0 < MAX_VAL <= 2**WIDTH-1.
- PRE_W, 4, prescaler reload width in bits.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- res  in  1  asynchronous, active-low reset.
- EN  in  1  count enable; also gates the prescaler.
- load  in  1  synchronous load of CNT_In.
- CNT_In  in  WIDTH  load value.
- up_dn  in  1  direction: 1 = up, 0 = down.
- mode  in  2  count mode: 00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
- prescale  in  PRE_W  tick every prescale+1 enabled cycles.
- CNT  out  WIDTH  current count.
- TC  out  1  registered one-cycle terminal-count pulse.
- done  out  1  one-shot finished flag.

Behaviour:
- Reset:
  - res=0 forces CNT=0, TC=0, done=0, prescaler phase pc=0, FSM=IDLE immediately, with no clock edge needed.
  - Release is synchronous to the next clk edge.
- Priority per edge: res > load > tick > hold.
- Load:
  - CNT <= min(CNT_In, MAX_VAL), pc <= 0, TC <= 0.
  - Takes effect regardless of EN. A held load keeps reloading every edge.
- Prescaler:
  - pc counts 0..prescale only while EN=1.
  - tick = EN && (pc==prescale); pc wraps to 0 on tick.
  - prescale=0 gives a tick every enabled cycle.
  - EN=0 freezes both pc and CNT.
  - If prescale changes while pc > prescale, the next edge sets pc=0 with no tick.
- Terminal condition: term = up_dn ? (CNT==MAX_VAL) : (CNT==0).
- Wrap mode, on tick:
  - If term: up gives CNT<=0, down gives CNT<=MAX_VAL, and TC<=1.
  - Otherwise CNT±1.
- Saturate mode, on tick:
  - If term: CNT holds, no TC.
  - Else CNT±1. TC<=1 only on the edge where CNT±1 equals the terminal value.
- One-shot mode, FSM states IDLE / RUN / DONE:
  - IDLE: CNT holds on ticks; load → RUN.
  - RUN: ticks count as in saturate mode. The tick reaching the terminal value → DONE with TC<=1.
  - Load while RUN reloads and stays in RUN.
  - DONE: CNT holds, done=1; load → RUN and done clears on that edge.
  - Loading a value already at terminal goes to RUN; the next tick → DONE with TC pulse and no count change.
- Mode not one-shot:
  - FSM is forced to IDLE and done=0 on the next edge.
  - Mode changes take effect on the next edge and never corrupt CNT.
- TC:
  - Registered, high for exactly one clk cycle following the qualifying edge.
  - 0 on every other edge, including edges where EN=0.
- Direction change takes effect on the next tick.
- Latency: load and tick both update CNT one edge after being sampled.
- Arithmetic is modulo 2**WIDTH internally, but CNT never exceeds MAX_VAL.

Decomposition:
- Shared include count_defs.v holds the mode encodings (MODE_WRAP=2'b00, MODE_SAT=2'b01, MODE_ONESHOT=2'b10) and the FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- One sub-module, count_prescale:
  - Parameter PRE_W.
  - Ports clk, res, EN, clr (=load), prescale; output tick.

Test Plan:
- Reset and up-count (WIDTH=8, wrap, up, prescale=0):
  - Hold res=0, then release with EN=1 → CNT 00,01,02… one per edge.
  - Drive res=0 mid-count at CNT=05 → CNT=00 before the next clk edge.
- Load and enable:
  - Load=1 with CNT_In=8'h11 for 2 edges → CNT=11 on both edges; load=0 → 12, 13.
  - EN=0 for 5 edges → CNT frozen at 13 with TC=0; EN=1 → 14.
- Wrap both directions:
  - Load FE, up → FF then 00, with TC high exactly the one cycle after the FF→00 edge.
  - Load 01, down → 00 then FF, with TC pulse once.
- Saturate and clamp (WIDTH=4, MAX_VAL=9):
  - Load 7, up → 8, 9, 9, 9, with a single TC after 8→9.
  - Load CNT_In=15 → CNT=9.
  - Down from 1 → 0, 0, with TC once.
- Prescale=3:
  - CNT increments every 4th enabled edge.
  - Drop EN for 3 edges at pc=2 → the next increment arrives after 2 more enabled edges.
  - Load clears phase.
- One-shot (mode=10, down):
  - Load 5 → 4, 3, 2, 1, 0; then done=1, TC one pulse, CNT holds 0 for 10 edges.
  - Load 2 → done=0 on the load edge, counts to 0, done=1 again.
  - Switching mode to 00 → done=0 on the next edge.

Source files
------------

// File: rtl/count_n_modal_pkg.sv
// count_n_modal_pkg: mode and one-shot state encodings shared by the counter.
package count_n_modal_pkg;
  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/count_n_modal_prescale.sv
// count_n_modal_prescale: clock-enable divider, ticks every prescale+1 enabled cycles.
module count_n_modal_prescale #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             EN,
  input  logic             clr,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);
  logic [PRE_W-1:0] pc_q, pc_d;
  assign tick = EN && (pc_q == prescale);
  // a phase left above a lowered prescale restarts without ticking
  always_comb pc_d = (clr || (EN && pc_q >= prescale)) ? '0 : EN ? pc_q + 1'b1 : pc_q;
  always_ff @(posedge clk or negedge res)
    if (!res) pc_q <= '0;
    else      pc_q <= pc_d;
endmodule

// File: rtl/count_n_modal.sv
// count_n_modal: N-bit up/down counter with wrap, saturate and one-shot modes.
module count_n_modal
  import count_n_modal_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter int PRE_W   = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             EN,
  input  logic             load,
  input  logic [WIDTH-1:0] CNT_In,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] CNT,
  output logic             TC,
  output logic             done
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  logic [WIDTH-1:0] cnt_q, cnt_d, step, target, ld_val;
  logic             tc_q, tc_d, tick, term, hit, oneshot;
  state_e           st_q, st_d;
  count_n_modal_prescale #(.PRE_W(PRE_W)) u_pre (
    .clk(clk), .res(res), .EN(EN), .clr(load), .prescale(prescale), .tick(tick)
  );
  assign oneshot = mode == MODE_ONESHOT;
  assign target  = up_dn ? MAXV : '0;
  assign term    = cnt_q == target;
  assign step    = up_dn ? cnt_q + 1'b1 : cnt_q - 1'b1;
  assign hit     = term || step == target;
  assign ld_val  = CNT_In > MAXV ? MAXV : CNT_In;
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    st_d  = oneshot ? st_q : IDLE;
    if (load) begin
      cnt_d = ld_val;
      st_d  = oneshot ? RUN : IDLE;
    end else if (tick) begin
      if (mode == MODE_SAT) begin
        cnt_d = term ? cnt_q : step;
        tc_d  = !term && step == target;
      end else if (oneshot) begin
        if (st_q == RUN) begin
          cnt_d = term ? cnt_q : step;
          tc_d  = hit;
          st_d  = hit ? DONE : RUN;
        end
      end else begin
        cnt_d = term ? (up_dn ? '0 : MAXV) : step;
        tc_d  = term;
      end
    end
  end
  always_ff @(posedge clk or negedge res)
    if (!res) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      st_q  <= IDLE;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      st_q  <= st_d;
    end
  assign CNT  = cnt_q;
  assign TC   = tc_q;
  assign done = st_q == DONE;
endmodule

// File: tb/tb_count_n_modal.sv
// tb_count_n_modal: directed and random checks of two counter instances against a model.
module tb_count_n_modal;
  logic clk = 0, res = 0, en = 0, load = 0, up_dn = 1;
  logic [1:0] mode = 0;
  logic [3:0] pre = 0;
  logic [7:0] cin = 0;
  logic [7:0] cnt_a;
  logic [3:0] cnt_b;
  logic tc_a, done_a, tc_b, done_b;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  count_n_modal #(.WIDTH(8)) dut_a (
    .clk(clk), .res(res), .EN(en), .load(load), .CNT_In(cin), .up_dn(up_dn),
    .mode(mode), .prescale(pre), .CNT(cnt_a), .TC(tc_a), .done(done_a)
  );
  count_n_modal #(.WIDTH(4), .MAX_VAL(9)) dut_b (
    .clk(clk), .res(res), .EN(en), .load(load), .CNT_In(cin[3:0]), .up_dn(up_dn),
    .mode(mode), .prescale(pre), .CNT(cnt_b), .TC(tc_b), .done(done_b)
  );
  typedef struct {int cnt; int pc; int tc; int st;} ms_t;
  ms_t ma = '{0, 0, 0, 0};
  ms_t mb = '{0, 0, 0, 0};
  function automatic ms_t mstep(ms_t s, int maxv, int w);
    ms_t n = s;
    int tgt = up_dn ? maxv : 0;
    int d = up_dn ? 1 : -1;
    int lv = int'(cin) & ((1 << w) - 1);
    bit tk = en && s.pc == int'(pre);
    n.tc = 0;
    if (load) begin
      n.cnt = lv > maxv ? maxv : lv;
      n.pc = 0;
      n.st = mode == 2 ? 1 : 0;
      return n;
    end
    if (en) n.pc = s.pc >= int'(pre) ? 0 : s.pc + 1;
    if (mode != 2) n.st = 0;
    if (!tk) return n;
    case (mode)
      2'd1: if (s.cnt != tgt) begin n.cnt = s.cnt + d; n.tc = n.cnt == tgt; end
      2'd2: if (s.st == 1) begin
        if (s.cnt != tgt) n.cnt = s.cnt + d;
        if (n.cnt == tgt) begin n.tc = 1; n.st = 2; end
      end
      default: if (s.cnt == tgt) begin n.cnt = up_dn ? 0 : maxv; n.tc = 1; end
               else n.cnt = s.cnt + d;
    endcase
    return n;
  endfunction
  always @(posedge clk or negedge res)
    if (!res) begin
      ma = '{0, 0, 0, 0};
      mb = '{0, 0, 0, 0};
    end else begin
      ma = mstep(ma, 255, 8);
      mb = mstep(mb, 9, 4);
    end
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    else passed++;
  endtask
  always @(negedge clk) begin
    chk("cnt_a", cnt_a, ma.cnt);
    chk("tc_a", tc_a, ma.tc);
    chk("done_a", done_a, ma.st == 2);
    chk("cnt_b", cnt_b, mb.cnt);
    chk("tc_b", tc_b, mb.tc);
    chk("done_b", done_b, mb.st == 2);
  end
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    step(2);
    chk("reset_cnt", cnt_a, 0);
    res = 1; en = 1;
    step(5);
    chk("count5", cnt_a, 5);
    #2 res = 0;
    #1 chk("async_rst", cnt_a, 0);
    step(1); res = 1;
    load = 1; cin = 8'h11;
    step(1); chk("load1", cnt_a, 8'h11);
    step(1); chk("load2", cnt_a, 8'h11);
    load = 0;
    step(2); chk("after_load", cnt_a, 8'h13);
    en = 0;
    step(5); chk("frozen", cnt_a, 8'h13); chk("frozen_tc", tc_a, 0);
    en = 1;
    step(1); chk("resume", cnt_a, 8'h14);
    load = 1; cin = 8'hFE;
    step(1); load = 0;
    step(1); chk("up_ff", cnt_a, 8'hFF); chk("up_ff_tc", tc_a, 0);
    step(1); chk("up_wrap", cnt_a, 0); chk("up_wrap_tc", tc_a, 1);
    step(1); chk("up_tc_gone", tc_a, 0);
    load = 1; cin = 8'h01;
    step(1); load = 0; up_dn = 0;
    step(1); chk("dn_zero", cnt_a, 0);
    step(1); chk("dn_wrap", cnt_a, 8'hFF); chk("dn_wrap_tc", tc_a, 1);
    step(1); chk("dn_tc_gone", tc_a, 0);
    mode = 1; up_dn = 1; load = 1; cin = 7;
    step(1); chk("sat_ld", cnt_b, 7); load = 0;
    step(1); chk("sat_8", cnt_b, 8); chk("sat_8_tc", tc_b, 0);
    step(1); chk("sat_9", cnt_b, 9); chk("sat_9_tc", tc_b, 1);
    step(2); chk("sat_hold", cnt_b, 9); chk("sat_hold_tc", tc_b, 0);
    load = 1; cin = 15;
    step(1); chk("clamp", cnt_b, 9);
    cin = 1;
    step(1); load = 0; up_dn = 0;
    step(1); chk("sat_dn0", cnt_b, 0); chk("sat_dn0_tc", tc_b, 1);
    step(1); chk("sat_dn_hold", cnt_b, 0); chk("sat_dn_tc", tc_b, 0);
    mode = 0; up_dn = 1; pre = 3; load = 1; cin = 0;
    step(1); load = 0;
    step(3); chk("pre_wait", cnt_a, 0);
    step(1); chk("pre_tick", cnt_a, 1);
    step(2); en = 0;
    step(3); en = 1;
    step(1); chk("pre_en_wait", cnt_a, 1);
    step(1); chk("pre_en_tick", cnt_a, 2);
    step(2); load = 1; cin = 8'h40;
    step(1); load = 0;
    step(3); chk("pre_clr_wait", cnt_a, 8'h40);
    step(1); chk("pre_clr_tick", cnt_a, 8'h41);
    pre = 0; mode = 2; up_dn = 0; load = 1; cin = 5;
    step(1); chk("os_ld", cnt_a, 5); chk("os_ld_done", done_a, 0); load = 0;
    step(4); chk("os_1", cnt_a, 1);
    step(1); chk("os_0", cnt_a, 0); chk("os_done", done_a, 1); chk("os_tc", tc_a, 1);
    step(10); chk("os_hold", cnt_a, 0); chk("os_hold_done", done_a, 1); chk("os_hold_tc", tc_a, 0);
    load = 1; cin = 2;
    step(1); chk("os_rld", cnt_a, 2); chk("os_rld_done", done_a, 0); load = 0;
    step(2); chk("os2_0", cnt_a, 0); chk("os2_done", done_a, 1);
    mode = 0;
    step(1); chk("os_exit_done", done_a, 0);
    repeat (3000) begin
      @(negedge clk);
      #2;
      res   = $urandom_range(0, 99) != 0;
      load  = $urandom_range(0, 7) == 0;
      en    = $urandom_range(0, 3) != 0;
      up_dn = 1'($urandom);
      mode  = 2'($urandom);
      pre   = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'($urandom_range(0, 2));
      cin   = 8'($urandom);
    end
    res = 1;
    step(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
